// File: rtl/ysyx_25040109_pkg.sv
// Shared constants for the load/store unit: opcodes, width selectors, FSM states.
package ysyx_25040109_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ysyx_25040109_lsu_align.sv
// Combinational byte-lane steering for stores, load extraction/extension,
// and legality check of the access width against the address offset.
module ysyx_25040109_lsu_align
  import ysyx_25040109_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic              is_store,
  input  logic [1:0]        offset,
  input  logic [ADDR_W-1:0] store_data,
  input  logic [ADDR_W-1:0] rdata,
  output logic [3:0]        wmask,
  output logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] load_data,
  output logic              misaligned
);

  logic [ADDR_W-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  // Each lane picks its source byte: replicated byte, replicated half, or straight word.
  // Halfword lanes follow the 0011<<offset pattern, which for aligned halves is lane/2 == offset[1].
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata[8*gi +: 8] = (funct3[1:0] == 2'b00) ? store_data[7:0] :
                              (funct3[1:0] == 2'b01) ? store_data[8*(gi%2) +: 8] :
                                                       store_data[8*gi +: 8];
    assign wmask[gi] = (funct3[1:0] == 2'b00) ? (offset == 2'(gi)) :
                       (funct3[1:0] == 2'b01) ? (offset[1] == 1'(gi / 2)) :
                                                1'b1;
  end

  // Load extraction with sign or zero extension from the shifted word.
  always_comb begin
    load_data = shifted;
    unique case (funct3)
      F3_B:    load_data = {{(ADDR_W-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {{(ADDR_W-8){1'b0}}, shifted[7:0]};
      F3_H:    load_data = {{(ADDR_W-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {{(ADDR_W-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Unsigned widths exist only for loads; any unknown width is reported as misaligned.
  always_comb begin
    misaligned = 1'b1;
    unique case (funct3)
      F3_B:    misaligned = 1'b0;
      F3_BU:   misaligned = is_store;
      F3_H:    misaligned = offset[0];
      F3_HU:   misaligned = is_store | offset[0];
      F3_W:    misaligned = (offset != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_25040109_lsu.sv
// Load/store stage: one instruction at a time, single-outstanding memory port,
// registered writeback output with valid/ready.
module ysyx_25040109_lsu
  import ysyx_25040109_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_result,
  input  logic [ADDR_W-1:0] in_store_data,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_we,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd,
  output logic              out_reg_we,
  output logic [ADDR_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_fault
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state, state_next;
  logic [TW-1:0]     timer_reg;
  logic [2:0]        funct3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] sdata_reg;
  logic              is_load_reg;
  logic              is_store_reg;

  logic              new_is_load, new_is_store, new_is_mem;
  logic              idle, at_limit;
  logic              take, land, expire;
  logic [2:0]        al_funct3;
  logic [1:0]        al_offset;
  logic              al_store;
  logic [3:0]        al_wmask;
  logic [ADDR_W-1:0] al_wdata, al_load;
  logic              al_mis;

  assign new_is_load  = (in_opcode == OP_LOAD);
  assign new_is_store = (in_opcode == OP_STORE);
  assign new_is_mem   = new_is_load | new_is_store;
  assign idle         = (state == IDLE);
  // Once past the limit (a grant arrived on the last REQ cycle) RESP expires at once.
  assign at_limit     = (timer_reg >= TW'(TIMEOUT - 1));

  // In IDLE the aligner judges the incoming instruction; afterwards it serves the latched one.
  assign al_funct3 = idle ? in_funct3       : funct3_reg;
  assign al_offset = idle ? in_result[1:0]  : addr_reg[1:0];
  assign al_store  = idle ? new_is_store    : is_store_reg;

  ysyx_25040109_lsu_align #(.ADDR_W(ADDR_W)) u_align (
    .funct3     (al_funct3),
    .is_store   (al_store),
    .offset     (al_offset),
    .store_data (sdata_reg),
    .rdata      (mem_rdata),
    .wmask      (al_wmask),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_mis)
  );

  // Request fields are driven only while the request is up, so idle/reset shows zeros.
  assign mem_we    = mem_req & is_store_reg;
  assign mem_addr  = mem_req ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_we ? al_wdata : '0;
  assign mem_wmask = mem_we ? al_wmask : 4'b0000;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state, handshake outputs and datapath update strobes.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mem_req    = 1'b0;
    out_valid  = 1'b0;
    take       = 1'b0;
    land       = 1'b0;
    expire     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          take       = 1'b1;
          state_next = (!new_is_mem || al_mis) ? DONE : REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt && mem_rvalid) begin
          land       = 1'b1;
          state_next = DONE;
        end else if (mem_gnt) begin
          state_next = RESP;
        end else if (at_limit) begin
          expire     = 1'b1;
          state_next = DONE;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          land       = 1'b1;
          state_next = DONE;
        end else if (at_limit) begin
          expire     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the instruction on accept and build the writeback record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_reg   <= '0;
      addr_reg     <= '0;
      sdata_reg    <= '0;
      is_load_reg  <= 1'b0;
      is_store_reg <= 1'b0;
      out_rd       <= '0;
      out_pc       <= '0;
      out_data     <= '0;
      out_reg_we   <= 1'b0;
      out_fault    <= 1'b0;
    end else begin
      if (take) begin
        funct3_reg   <= in_funct3;
        addr_reg     <= in_result;
        sdata_reg    <= in_store_data;
        is_load_reg  <= new_is_load;
        is_store_reg <= new_is_store;
        out_rd       <= in_rd;
        out_pc       <= in_pc;
        if (!new_is_mem) begin
          out_data   <= in_result;
          out_reg_we <= in_reg_we;
          out_fault  <= 1'b0;
        end else if (al_mis) begin
          out_data   <= '0;
          out_reg_we <= 1'b0;
          out_fault  <= 1'b1;
        end else begin
          out_data   <= '0;
          out_reg_we <= in_reg_we & new_is_load;
          out_fault  <= 1'b0;
        end
      end
      if (land && is_load_reg) out_data <= al_load;
      if (expire) begin
        out_data   <= '0;
        out_reg_we <= 1'b0;
        out_fault  <= 1'b1;
      end
    end
  end

  // Wait-cycle counter: cleared on accept, advanced while a memory access is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             timer_reg <= '0;
    else if (take)                          timer_reg <= '0;
    else if (state == REQ || state == RESP) timer_reg <= timer_reg + TW'(1);
  end

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Directed bench for the LSU with a spec-level transaction model and a
// per-cycle compare process.
module tb_ysyx_25040109_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_result, in_store_data, in_pc;
  logic [4:0]  in_rd;
  logic        in_reg_we;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        out_valid, out_ready, out_reg_we, out_fault;
  logic [4:0]  out_rd;
  logic [31:0] out_data, out_pc;

  always #5 clk = ~clk;

  ysyx_25040109_lsu #(.ADDR_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_result(in_result), .in_store_data(in_store_data), .in_rd(in_rd),
    .in_reg_we(in_reg_we), .in_pc(in_pc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_reg_we(out_reg_we),
    .out_data(out_data), .out_pc(out_pc), .out_fault(out_fault)
  );

  typedef struct {
    logic        has_mem;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] data;
    logic        chk_data;
    logic        reg_we;
    logic        fault;
    logic [4:0]  rd;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   txn_id    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endtask

  // Expected outcome of one instruction, from access size and byte offset arithmetic.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input logic we,
                                 input logic [4:0] rd, input logic [31:0] pc,
                                 input logic timeout);
    exp_t e;
    int size, off;
    logic ld, st, bad;
    logic [31:0] w, b;
    ld = (op == 7'h03);
    st = (op == 7'h23);
    e = '{has_mem: 1'b0, we: 1'b0, maddr: 32'h0, wdata: 32'h0, wmask: 4'h0, data: 32'h0,
          chk_data: 1'b0, reg_we: 1'b0, fault: 1'b0, rd: rd, pc: pc};
    if (!ld && !st) begin
      e.data = addr; e.chk_data = 1'b1; e.reg_we = we;
      return e;
    end
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    off = int'(addr % 4);
    bad = (size == 0) || (st && f3 > 3'd2);
    if (!bad && (off % size) != 0) bad = 1'b1;
    if (bad) begin
      e.fault = 1'b1;
      return e;
    end
    e.has_mem = 1'b1;
    e.we      = st;
    e.maddr   = addr - 32'(off);
    e.wmask   = 4'(((1 << size) - 1) << off);
    e.wdata   = (size == 1) ? {4{sdata[7:0]}} : (size == 2) ? {2{sdata[15:0]}} : sdata;
    if (timeout) begin
      e.fault = 1'b1;
    end else if (ld) begin
      w = rdata >> (8 * off);
      case (f3)
        3'd0: begin b = w & 32'hFF;   e.data = (b >= 32'h80)   ? (b | 32'hFFFFFF00) : b; end
        3'd4: e.data = w & 32'hFF;
        3'd1: begin b = w & 32'hFFFF; e.data = (b >= 32'h8000) ? (b | 32'hFFFF0000) : b; end
        3'd5: e.data = w & 32'hFFFF;
        default: e.data = w;
      endcase
      e.chk_data = 1'b1;
      e.reg_we   = we;
    end
    return e;
  endfunction

  // Per-cycle compare against the head of the expected queue.
  initial begin
    logic prev_valid, prev_ready;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_valid && !prev_ready) chk("valid_hold", out_valid, 1);
        if (mem_req) begin
          if (exp_q.size() == 0 || !exp_q[0].has_mem) begin
            total_cnt++;
            $display("FAIL spurious_req: mem_req=1 want 0");
          end else begin
            chk("mem_addr", mem_addr, exp_q[0].maddr);
            chk("mem_we", mem_we, exp_q[0].we);
            if (exp_q[0].we) begin
              chk("mem_wdata", mem_wdata, exp_q[0].wdata);
              chk("mem_wmask", mem_wmask, exp_q[0].wmask);
            end
          end
        end
        if (out_valid) begin
          chk("busy_not_ready", in_ready, 0);
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_out: out_valid=1 want 0");
          end else begin
            chk("out_rd", out_rd, exp_q[0].rd);
            chk("out_pc", out_pc, exp_q[0].pc);
            chk("out_fault", out_fault, exp_q[0].fault);
            chk("out_reg_we", out_reg_we, exp_q[0].reg_we);
            if (exp_q[0].chk_data) chk("out_data", out_data, exp_q[0].data);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
      prev_valid = out_valid & rst_n;
      prev_ready = out_ready;
    end
  end

  // Issue one instruction and play the memory side; gnt_delay < 0 means never grant.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata, input logic we,
                        input int gnt_delay, input int rv_delay, input int hold,
                        output logic [31:0] g_data, output logic g_fault, output logic g_we,
                        output logic [31:0] g_addr, output logic [31:0] g_wdata,
                        output logic [3:0] g_wmask, output int req_cycles);
    exp_t e;
    logic [4:0]  rd;
    logic [31:0] pc;
    txn_id++;
    rd = 5'(txn_id);
    pc = 32'h8000_1000 + 32'(txn_id * 4);
    e  = model(op, f3, addr, sdata, rdata, we, rd, pc, gnt_delay < 0);
    exp_q.push_back(e);
    chk("idle_before", in_ready, 1);
    out_ready     = (hold == 0);
    in_opcode     = op;
    in_funct3     = f3;
    in_result     = addr;
    in_store_data = sdata;
    in_rd         = rd;
    in_reg_we     = we;
    in_pc         = pc;
    in_valid      = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_result = ~addr; in_store_data = ~sdata; in_funct3 = ~f3; in_rd = ~rd; in_pc = ~pc;
    req_cycles = 0; g_addr = 0; g_wdata = 0; g_wmask = 0;
    if (e.has_mem) begin
      chk("req_cycle1", mem_req, 1);
      g_addr = mem_addr; g_wdata = mem_wdata; g_wmask = mem_wmask;
      if (gnt_delay < 0) begin
        for (int i = 0; i < 400 && !out_valid; i++) begin
          if (mem_req) req_cycles++;
          @(posedge clk); #1;
        end
      end else begin
        repeat (gnt_delay) begin
          chk("req_wait", mem_req, 1);
          req_cycles++;
          @(posedge clk); #1;
        end
        req_cycles++;
        mem_gnt = 1'b1;
        if (rv_delay == 0) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
        if (rv_delay > 0) begin
          chk("resp_no_req", mem_req, 0);
          repeat (rv_delay - 1) begin @(posedge clk); #1; end
          mem_rvalid = 1'b1; mem_rdata = rdata;
          @(posedge clk); #1;
          mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
        end
      end
    end else begin
      chk("no_req", mem_req, 0);
    end
    chk("latency_valid", out_valid, 1);
    g_data = out_data; g_fault = out_fault; g_we = out_reg_we;
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, a, wd;
    logic        f, w;
    logic [3:0]  m;
    int          rc;
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = 7'h0; in_funct3 = 3'h0; in_result = 32'h0;
    in_store_data = 32'h0; in_rd = 5'h0; in_reg_we = 1'b0; in_pc = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_out_fault", out_fault, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADDI pass-through
    run_op(7'h13, 3'd0, 32'h12345678, 32'h0, 32'h0, 1'b1, 0, 0, 0, d, f, w, a, wd, m, rc);
    chk("addi_data", d, 32'h12345678);
    chk("addi_we", w, 1);
    // branch-like, no write
    run_op(7'h63, 3'd1, 32'h00000004, 32'h0, 32'h0, 1'b0, 0, 0, 0, d, f, w, a, wd, m, rc);
    chk("br_we", w, 0);
    // LB / LBU
    run_op(7'h03, 3'd0, 32'h80000003, 32'h0, 32'h80FF7F01, 1'b1, 0, 0, 0, d, f, w, a, wd, m, rc);
    chk("lb_addr", a, 32'h80000000);
    chk("lb_data", d, 32'hFFFFFF80);
    run_op(7'h03, 3'd4, 32'h80000003, 32'h0, 32'h80FF7F01, 1'b1, 0, 0, 0, d, f, w, a, wd, m, rc);
    chk("lbu_data", d, 32'h00000080);
    // SH upper half
    run_op(7'h23, 3'd1, 32'h80000002, 32'h0000BEEF, 32'h0, 1'b1, 0, 0, 0, d, f, w, a, wd, m, rc);
    chk("sh_wmask", m, 4'b1100);
    chk("sh_wdata", wd, 32'hBEEFBEEF);
    chk("sh_we", w, 0);
    // SB lane 1, SW
    run_op(7'h23, 3'd0, 32'h80000001, 32'h123456A5, 32'h0, 1'b0, 0, 0, 0, d, f, w, a, wd, m, rc);
    chk("sb_wmask", m, 4'b0010);
    chk("sb_wdata", wd, 32'hA5A5A5A5);
    run_op(7'h23, 3'd2, 32'h80000004, 32'h11223344, 32'h0, 1'b0, 0, 1, 0, d, f, w, a, wd, m, rc);
    chk("sw_wmask", m, 4'hF);
    chk("sw_wdata", wd, 32'h11223344);
    // LH / LHU upper half
    run_op(7'h03, 3'd1, 32'h80000002, 32'h0, 32'h80011234, 1'b1, 0, 0, 0, d, f, w, a, wd, m, rc);
    chk("lh_data", d, 32'hFFFF8001);
    run_op(7'h03, 3'd5, 32'h80000002, 32'h0, 32'h80011234, 1'b1, 0, 0, 0, d, f, w, a, wd, m, rc);
    chk("lhu_data", d, 32'h00008001);
    // misaligned and illegal widths
    run_op(7'h03, 3'd2, 32'h80000001, 32'h0, 32'h0, 1'b1, 0, 0, 0, d, f, w, a, wd, m, rc);
    chk("lw_mis_fault", f, 1);
    chk("lw_mis_we", w, 0);
    run_op(7'h03, 3'd1, 32'h80000003, 32'h0, 32'h0, 1'b1, 0, 0, 0, d, f, w, a, wd, m, rc);
    chk("lh_mis_fault", f, 1);
    run_op(7'h03, 3'd3, 32'h80000000, 32'h0, 32'h0, 1'b1, 0, 0, 0, d, f, w, a, wd, m, rc);
    chk("bad_f3_fault", f, 1);
    run_op(7'h23, 3'd4, 32'h80000000, 32'h0, 32'h0, 1'b0, 0, 0, 0, d, f, w, a, wd, m, rc);
    chk("st_bu_fault", f, 1);
    // slow LW: gnt after 3 cycles, rvalid 2 later, out_ready held low 4 cycles
    run_op(7'h03, 3'd2, 32'h80000010, 32'h0, 32'hCAFEF00D, 1'b1, 3, 2, 4, d, f, w, a, wd, m, rc);
    chk("slow_req_cycles", rc, 4);
    chk("slow_data", d, 32'hCAFEF00D);
    // timeout: gnt never comes
    run_op(7'h03, 3'd2, 32'h80000020, 32'h0, 32'h0, 1'b1, -1, 0, 0, d, f, w, a, wd, m, rc);
    chk("to_req_cycles", rc, 255);
    chk("to_fault", f, 1);
    chk("to_we", w, 0);

    // reset during REQ drops mem_req asynchronously
    exp_q.push_back(model(7'h03, 3'd2, 32'h80000030, 32'h0, 32'h0, 1'b1, 5'd30, 32'h80002000, 1'b0));
    in_opcode = 7'h03; in_funct3 = 3'd2; in_result = 32'h80000030; in_rd = 5'd30;
    in_reg_we = 1'b1; in_pc = 32'h80002000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rq_req_up", mem_req, 1);
    rst_n = 1'b0; #1;
    chk("rq_req_drop", mem_req, 0);
    chk("rq_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    // reset during RESP, then a late rvalid
    exp_q.push_back(model(7'h03, 3'd2, 32'h80000030, 32'h0, 32'h0, 1'b1, 5'd30, 32'h80002000, 1'b0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("rs_in_resp", in_ready, 0);
    rst_n = 1'b0; #1;
    chk("rs_in_ready", in_ready, 1);
    chk("rs_out_valid", out_valid, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("late_rv_valid", out_valid, 0);
    chk("late_rv_ready", in_ready, 1);
    chk("late_rv_req", mem_req, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("late_rv_idle", out_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
